// File: rtl/trace_pkg.sv
// Shared definitions for the trace capture buffer.
//
// Contents:
//   trace_state_t  - controller state encoding (IDLE/ARMED/POST/DUMP)
//   DEF_*          - default parameter values for the buffer
//   TS_EN          - 1 when TRACE_TIMESTAMP_EN is defined, else 0; scales
//                    the timestamp field out of the entry width
//   clog2()        - pointer-width helper usable in constant expressions
//
// Optional feature macro: TRACE_TIMESTAMP_EN
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DUMP  = 2'd3
    } trace_state_t;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_DEPTH      = 64;
    localparam int DEF_POST_DEPTH = 32;
    localparam int DEF_TS_W       = 16;

`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_EN = 1;
`else
    localparam int TS_EN = 0;
`endif

    // Smallest r with 2**r >= value.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read
// port with a single cycle of read latency. Contents are never reset.
//
// Ports:
//   clk      - clock, rising edge
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - read strobe; rd_data updates only when asserted
//   rd_addr  - read address
//   rd_data  - registered read data, valid the cycle after rd_en
module trace_ram
    import trace_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    input  logic [clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]          rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // rd_data holds its value when rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/trace_capture_buffer.sv
// On-chip trace capture buffer. Once armed, valid samples are written into a
// circular RAM; a masked compare trigger starts a post-trigger countdown, and
// once that window is complete the stored entries are streamed out
// oldest-first over a valid/ready port.
//
// Optional feature macro: TRACE_TIMESTAMP_EN
//   When defined, a free-running TS_W-bit cycle counter is stored alongside
//   each sample and dump_data becomes {timestamp, sample}.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   arm        - start a capture run (only honoured in IDLE)
//   trig_val   - trigger compare value
//   trig_mask  - trigger compare mask, 1 = bit participates
//   cap_valid  - cap_data holds a sample this cycle
//   cap_data   - sample to capture
//   dump_valid - dump_data holds a buffered entry
//   dump_ready - sink accepts the entry
//   dump_data  - buffered entry (timestamp in MSBs when enabled)
//   state_o    - 0=IDLE, 1=ARMED, 2=POST, 3=DUMP
//   triggered  - a trigger occurred in the current run
//   count      - number of entries currently stored
module trace_capture_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int POST_DEPTH = DEF_POST_DEPTH,
    parameter int TS_W       = DEF_TS_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arm,
    input  logic [DATA_W-1:0]             trig_val,
    input  logic [DATA_W-1:0]             trig_mask,
    input  logic                          cap_valid,
    input  logic [DATA_W-1:0]             cap_data,
    output logic                          dump_valid,
    input  logic                          dump_ready,
    output logic [DATA_W+TS_EN*TS_W-1:0]  dump_data,
    output logic [1:0]                    state_o,
    output logic                          triggered,
    output logic [clog2(DEPTH):0]         count
);

    localparam int PTR_W   = clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_W + TS_EN * TS_W;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] POST_INIT = CNT_W'(POST_DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    trace_state_t state;
    trace_state_t state_next;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   wr_ptr_inc;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_inc;
    logic [CNT_W-1:0]   post_cnt;
    logic [CNT_W-1:0]   rd_left;
    logic               wr_en;
    logic               trig_hit;
    logic               pop;
    logic               rd_issue;
    logic               rd_pend;
    logic [1:0]         occ_after;
    logic               skid_valid;
    logic [ENTRY_W-1:0] skid_data;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    assign wr_entry = {ts, cap_data};
`else
    assign wr_entry = cap_data;
`endif

    assign state_o = state;

    // occ_after counts entries already owned by the output side (output
    // register, skid register, read in flight) minus the one leaving this
    // cycle. A new RAM read is only launched when the two holding registers
    // can absorb it, which is what lets dump_data stall without losing data
    // while still sustaining one beat per cycle.
    always_comb begin
        wr_en      = ((state == ARMED) || (state == POST)) && cap_valid;
        trig_hit   = cap_valid && (((cap_data ^ trig_val) & trig_mask) == '0);
        wr_ptr_inc = wr_ptr + 1'b1;
        count_inc  = (count == DEPTH_C) ? count : count + 1'b1;
        pop        = dump_valid && dump_ready;
        occ_after  = {1'b0, dump_valid} + {1'b0, skid_valid} + {1'b0, rd_pend}
                   - {1'b0, pop};
        rd_issue   = (state == DUMP) && (rd_left != '0) && (occ_after < 2'd2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (trig_hit) begin
                    state_next = (POST_DEPTH == 1) ? DUMP : POST;
                end
            end
            POST: begin
                if (cap_valid && (post_cnt == ONE_C)) begin
                    state_next = DUMP;
                end
            end
            DUMP: begin
                if (pop && (count == ONE_C)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pointers and counters. On the write that ends capture, the read
    // pointer is set to the oldest entry: when the buffer is full the low
    // bits of count are zero, so this lands on the next write slot, which
    // holds the oldest surviving sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            rd_left   <= '0;
            triggered <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        wr_ptr    <= '0;
                        count     <= '0;
                        triggered <= 1'b0;
                    end
                end
                ARMED, POST: begin
                    if (wr_en) begin
                        wr_ptr <= wr_ptr_inc;
                        count  <= count_inc;
                    end
                    if ((state == ARMED) && trig_hit) begin
                        triggered <= 1'b1;
                        post_cnt  <= POST_INIT;
                    end else if ((state == POST) && cap_valid) begin
                        post_cnt <= post_cnt - 1'b1;
                    end
                    if (state_next == DUMP) begin
                        rd_ptr  <= wr_ptr_inc - count_inc[PTR_W-1:0];
                        rd_left <= count_inc;
                    end
                end
                DUMP: begin
                    if (rd_issue) begin
                        rd_ptr  <= rd_ptr + 1'b1;
                        rd_left <= rd_left - 1'b1;
                    end
                    if (pop) begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output stage: the output register is refilled from the skid register
    // first (it is older) and then from the RAM read that just returned. A
    // RAM word arriving while the output is stalled parks in the skid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend    <= 1'b0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            rd_pend <= rd_issue;
            if (!dump_valid || pop) begin
                if (skid_valid) begin
                    dump_valid <= 1'b1;
                    dump_data  <= skid_data;
                    skid_valid <= rd_pend;
                    if (rd_pend) begin
                        skid_data <= rd_entry;
                    end
                end else if (rd_pend) begin
                    dump_valid <= 1'b1;
                    dump_data  <= rd_entry;
                end else begin
                    dump_valid <= 1'b0;
                end
            end else if (rd_pend) begin
                skid_valid <= 1'b1;
                skid_data  <= rd_entry;
            end
        end
    end

    trace_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Self-checking bench for trace_capture_buffer (DEPTH=8, POST_DEPTH=4).
// A behavioural model pushes every sample the buffer should keep into a
// scoreboard queue as it is driven; dump beats pop and compare against it.
// Optional feature macro: TRACE_TIMESTAMP_EN (adds the timestamp scenario).
module tb_trace_capture_buffer;
    import trace_pkg::*;

    localparam int DATA_W     = 32;
    localparam int DEPTH      = 8;
    localparam int POST_DEPTH = 4;
    localparam int TS_W       = 16;
    localparam int DW         = DATA_W + TS_EN * TS_W;
    localparam int CW         = clog2(DEPTH) + 1;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_POST  = 2;
    localparam int M_DUMP  = 3;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              arm        = 1'b0;
    logic [DATA_W-1:0] trig_val   = '0;
    logic [DATA_W-1:0] trig_mask  = '0;
    logic              cap_valid  = 1'b0;
    logic [DATA_W-1:0] cap_data   = '0;
    logic              dump_valid;
    logic              dump_ready = 1'b0;
    logic [DW-1:0]     dump_data;
    logic [1:0]        state_o;
    logic              triggered;
    logic [CW-1:0]     count;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                ts_q[$];
    int                m_state = M_IDLE;
    int                m_post  = 0;

    always #5 clk = ~clk;

    trace_capture_buffer #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .POST_DEPTH (POST_DEPTH),
        .TS_W       (TS_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm        (arm),
        .trig_val   (trig_val),
        .trig_mask  (trig_mask),
        .cap_valid  (cap_valid),
        .cap_data   (cap_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .state_o    (state_o),
        .triggered  (triggered),
        .count      (count)
    );

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        m_state = M_ARMED;
        exp_q.delete();
        checks++;
        if (state_o !== 2'd1) begin
            errors++;
            $display("[TB] FAIL arm_state: got %0d want 1", state_o);
        end
        checks++;
        if (count !== '0) begin
            errors++;
            $display("[TB] FAIL arm_count: got %0d want 0", count);
        end
        checks++;
        if (triggered !== 1'b0) begin
            errors++;
            $display("[TB] FAIL arm_triggered: got %b want 0", triggered);
        end
    endtask

    // Drive one cycle of capture input and advance the model.
    task automatic drive_sample(input logic v, input logic [DATA_W-1:0] d);
        cap_valid = v;
        cap_data  = d;
        if (v && (m_state == M_ARMED || m_state == M_POST)) begin
            exp_q.push_back(d);
            if (exp_q.size() > DEPTH) exp_q.delete(0);
            if (m_state == M_ARMED) begin
                if (((d ^ trig_val) & trig_mask) == '0) begin
                    if (POST_DEPTH == 1) m_state = M_DUMP;
                    else begin
                        m_post  = POST_DEPTH - 1;
                        m_state = M_POST;
                    end
                end
            end else begin
                if (m_post == 1) m_state = M_DUMP;
                else m_post--;
            end
        end
        tick();
        cap_valid = 1'b0;
    endtask

    task automatic check_dump_entry(input string name);
        checks++;
        if (state_o !== 2'd3) begin
            errors++;
            $display("[TB] FAIL %s_state: got %0d want 3", name, state_o);
        end
        checks++;
        if (count !== CW'(exp_q.size())) begin
            errors++;
            $display("[TB] FAIL %s_count: got %0d want %0d", name, count, exp_q.size());
        end
        checks++;
        if (triggered !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_triggered: got %b want 1", name, triggered);
        end
    endtask

    // Consume the dump. mode 0: ready always high; mode 1: ready alternates.
    // stop_beat > 0 applies a one-cycle reset on that beat instead.
    task automatic drain(input int mode, input int stop_beat);
        int                cyc       = 0;
        int                beats     = 0;
        int                first_cyc = -1;
        int                last_cyc  = -1;
        logic              stalled   = 1'b0;
        logic [DW-1:0]     held      = '0;
        logic              rdy;
        logic [DATA_W-1:0] want;
        ts_q.delete();
        while (exp_q.size() > 0 && cyc < 200) begin
            if (stalled) begin
                checks++;
                if (dump_valid !== 1'b1 || dump_data !== held) begin
                    errors++;
                    $display("[TB] FAIL hold: got valid=%b data=%h want valid=1 data=%h",
                             dump_valid, dump_data, held);
                end
            end
            rdy = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (dump_valid === 1'b1 && rdy) begin
                beats++;
                if (beats == stop_beat) begin
                    rst_n      = 1'b0;
                    dump_ready = 1'b1;
                    tick();
                    rst_n      = 1'b1;
                    dump_ready = 1'b0;
                    exp_q.delete();
                    m_state = M_IDLE;
                    return;
                end
                want = exp_q.pop_front();
                checks++;
                if (dump_data[DATA_W-1:0] !== want) begin
                    errors++;
                    $display("[TB] FAIL beat%0d: got %h want %h", beats, dump_data[DATA_W-1:0], want);
                end
`ifdef TRACE_TIMESTAMP_EN
                ts_q.push_back(int'(dump_data[DW-1:DATA_W]));
`endif
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            stalled    = (dump_valid === 1'b1) && !rdy;
            held       = dump_data;
            dump_ready = rdy;
            tick();
            cyc++;
        end
        dump_ready = 1'b0;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d beats want %0d more", beats, exp_q.size());
            exp_q.delete();
        end else begin
            m_state = M_IDLE;
            checks++;
            if (dump_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL end_valid: got %b want 0", dump_valid);
            end
            checks++;
            if (state_o !== 2'd0) begin
                errors++;
                $display("[TB] FAIL end_state: got %0d want 0", state_o);
            end
            checks++;
            if (count !== '0) begin
                errors++;
                $display("[TB] FAIL end_count: got %0d want 0", count);
            end
            if (mode == 0) begin
                checks++;
                if (last_cyc - first_cyc + 1 != beats) begin
                    errors++;
                    $display("[TB] FAIL throughput: got %0d cycles want %0d",
                             last_cyc - first_cyc + 1, beats);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("[TB] FAIL rst_state: got %0d want 0", state_o); end
        checks++;
        if (dump_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b want 0", dump_valid); end
        checks++;
        if (dump_data !== '0) begin errors++; $display("[TB] FAIL rst_data: got %h want 0", dump_data); end
        checks++;
        if (triggered !== 1'b0) begin errors++; $display("[TB] FAIL rst_triggered: got %b want 0", triggered); end
        checks++;
        if (count !== '0) begin errors++; $display("[TB] FAIL rst_count: got %0d want 0", count); end
    endtask

    task automatic test_full_window();
        trig_mask = '1;
        trig_val  = 32'd10;
        do_arm();
        for (int i = 0; i < 20; i++) drive_sample(1'b1, DATA_W'(i));
        check_dump_entry("full");
        checks++;
        if (count !== CW'(DEPTH)) begin
            errors++;
            $display("[TB] FAIL full_depth: got %0d want %0d", count, DEPTH);
        end
        drain(0, 0);
        checks++;
        if (triggered !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_trig_kept: got %b want 1", triggered);
        end
    endtask

    task automatic test_early_trigger();
        trig_mask = '1;
        trig_val  = 32'd5;
        do_arm();
        for (int i = 5; i < 10; i++) drive_sample(1'b1, DATA_W'(i));
        check_dump_entry("early");
        drain(0, 0);
    endtask

    task automatic test_mask();
        trig_mask = 32'h0000_007F;
        trig_val  = 32'h0000_0013;
        do_arm();
        drive_sample(1'b1, 32'h0000_0012);
        checks++;
        if (state_o !== 2'd1 || triggered !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mask_nomatch: got state=%0d trig=%b want state=1 trig=0", state_o, triggered);
        end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks++;
        if (state_o !== 2'd1 || count !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL arm_ignored: got state=%0d count=%0d want state=1 count=1", state_o, count);
        end
        drive_sample(1'b1, 32'hABCD_0013);
        checks++;
        if (state_o !== 2'd2 || triggered !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mask_match: got state=%0d trig=%b want state=2 trig=1", state_o, triggered);
        end
        for (int i = 0; i < 3; i++) drive_sample(1'b1, 32'h5500_0000 + DATA_W'(i));
        check_dump_entry("mask");
        drain(1, 0);
    endtask

    task automatic test_backpressure_gaps();
        logic pattern [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        trig_mask = '0;
        trig_val  = '0;
        do_arm();
        for (int i = 0; i < 7; i++) begin
            drive_sample(pattern[i], 32'h0000_0100 + DATA_W'(i));
            checks++;
            if (state_o !== 2'(m_state)) begin
                errors++;
                $display("[TB] FAIL gap_state%0d: got %0d want %0d", i, state_o, m_state);
            end
        end
        check_dump_entry("gaps");
        drain(1, 0);
    endtask

    task automatic test_reset_mid_dump();
        trig_mask = '0;
        do_arm();
        for (int i = 0; i < 4; i++) drive_sample(1'b1, 32'hC0DE_0000 + DATA_W'(i));
        check_dump_entry("midrst");
        drain(0, 3);
        checks++;
        if (dump_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b want 0", dump_valid); end
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("[TB] FAIL midrst_state: got %0d want 0", state_o); end
        checks++;
        if (count !== '0) begin errors++; $display("[TB] FAIL midrst_count: got %0d want 0", count); end
        checks++;
        if (triggered !== 1'b0) begin errors++; $display("[TB] FAIL midrst_trig: got %b want 0", triggered); end
    endtask

`ifdef TRACE_TIMESTAMP_EN
    task automatic test_timestamp();
        trig_mask = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        arm   = 1'b1;
        tick();
        arm   = 1'b0;
        m_state = M_ARMED;
        exp_q.delete();
        tick();
        tick();
        for (int i = 0; i < 4; i++) drive_sample(1'b1, 32'hFACE_0000 + DATA_W'(i));
        drain(0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= ts_q.size() || ts_q[i] != 3 + i) begin
                errors++;
                $display("[TB] FAIL ts%0d: got %0d want %0d", i, (i < ts_q.size()) ? ts_q[i] : -1, 3 + i);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_window();
        test_early_trigger();
        test_mask();
        test_backpressure_gaps();
        test_reset_mid_dump();
        test_early_trigger();
`ifdef TRACE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
